// File: rtl/ripple_carry.sv
// Registered unsigned ripple-carry adder.
// A chain of 1-bit full-adder cells feeds an output register.

module ripple_carry_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module ripple_carry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ripple_carry_cell u_cell (
      .a     (a_in[i]),
      .b     (b_in[i]),
      .c_in  (c[i]),
      .s     (s[i]),
      .c_out (c[i+1])
    );
  end

  // capture the chain result; reset clears it at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      sum_out   <= s;
      carry_out <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_ripple_carry.sv
// Bench for ripple_carry: 4-bit and 8-bit builds.
// Expected sums come from plain integer addition.

module tb_ripple_carry;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] a4, b4, s4;
  logic       c4, co4;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;

  int n_tests = 0;
  int n_fail  = 0;
  int exp4    = 0;
  int exp8    = 0;

  always #5 clk = ~clk;

  ripple_carry #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a4),
    .b_in      (b4),
    .carry_in  (c4),
    .sum_out   (s4),
    .carry_out (co4)
  );

  ripple_carry #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a8),
    .b_in      (b8),
    .carry_in  (c8),
    .sum_out   (s8),
    .carry_out (co8)
  );

  task automatic check(
    input string       tag,
    input logic [64:0] got,
    input logic [64:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic rand8();
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    c8 = 1'($urandom);
  endtask

  // inputs already driven, called just after an edge
  task automatic cycle(input string tag, input bit hold);
    int n4, n8;
    n4 = int'(a4) + int'(b4) + int'(c4);
    n8 = int'(a8) + int'(b8) + int'(c8);
    #2;
    if (hold) begin
      check({tag, "_hold4"}, {co4, s4}, exp4);
      check({tag, "_hold8"}, {co8, s8}, exp8);
    end
    @(posedge clk);
    #1;
    exp4 = n4;
    exp8 = n8;
    check({tag, "_4"}, {co4, s4}, exp4);
    check({tag, "_8"}, {co8, s8}, exp8);
  endtask

  initial begin
    rst = 1'b1;
    a4  = 4'b1011;
    b4  = 4'b0100;
    c4  = 1'b0;
    rand8();
    #1;
    check("rst_now4", {co4, s4}, 0);
    check("rst_now8", {co8, s8}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_edges4", {co4, s4}, 0);
    check("rst_edges8", {co8, s8}, 0);

    @(negedge clk);
    rst = 1'b0;
    a4  = 4'b0000;
    b4  = 4'b0000;
    c4  = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;
    c8  = 1'b0;
    exp4 = 0;
    exp8 = 0;
    @(posedge clk);
    #1;
    check("zero4", {co4, s4}, 0);
    check("zero8", {co8, s8}, 0);

    a4 = 4'b1011; b4 = 4'b0100; c4 = 1'b0;
    a8 = 8'hff;   b8 = 8'hff;   c8 = 1'b1;
    cycle("d1011p0100", 1'b1);
    check("d1_lit", {co4, s4}, 5'b01111);

    a4 = 4'b1111; b4 = 4'b1101; c4 = 1'b1;
    rand8();
    cycle("d1111p1101c", 1'b1);
    check("d2_lit", {co4, s4}, 5'b11101);

    a4 = 4'b1111; b4 = 4'b1111; c4 = 1'b1;
    a8 = 8'hff;   b8 = 8'h00;   c8 = 1'b1;
    cycle("allones", 1'b1);
    check("d3_lit", {co4, s4}, 5'b11111);

    a4 = 4'b1111; b4 = 4'b0000; c4 = 1'b1;
    rand8();
    cycle("ripple", 1'b1);
    check("d4_lit", {co4, s4}, 5'b10000);

    #2;
    rst = 1'b1;
    #1;
    check("async_rst4", {co4, s4}, 0);
    check("async_rst8", {co8, s8}, 0);
    @(posedge clk);
    #1;
    check("rst_hold4", {co4, s4}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp4 = 0;
    exp8 = 0;
    a4 = 4'b0110; b4 = 4'b0011; c4 = 1'b1;
    rand8();
    cycle("post_rst", 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v  = 9'(i);
      a4 = v[3:0];
      b4 = v[7:4];
      c4 = v[8];
      rand8();
      cycle("exh", 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      c4 = 1'($urandom);
      rand8();
      cycle("rnd", (i % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_carry.md
Name: ripple_carry

Overview:
- Parameterised unsigned binary adder built as an explicit chain of 1-bit full-adder cells.
- The carry ripples from bit 0 to bit WIDTH-1.
- Result (sum and carry-out) is captured in an output register, so downstream logic sees a clean registered value one clock after the operands are presented.
- Used as the basic arithmetic primitive in the datapath adder library; default build is a 4-bit adder.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- carry_in  input  1  carry into bit 0.
- sum_out  output  WIDTH  registered sum bits.
- carry_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Combinational core: WIDTH full-adder cells in a chain.
  - Cell i: s[i] = a_in[i] ^ b_in[i] ^ c[i].
  - Cell i: c[i+1] = (a_in[i] & b_in[i]) | (a_in[i] & c[i]) | (b_in[i] & c[i]).
  - c[0] = carry_in.
- Required result: {c[WIDTH], s} == a_in + b_in + carry_in, exact, (WIDTH+1) bits, no saturation.
- Implementation: cells instantiated via generate loop from a separate 1-bit full-adder submodule. A behavioural "+" operator is not permitted.
- Output register: on each rising clk edge, sum_out <= s and carry_out <= c[WIDTH].
  - Latency exactly 1 cycle.
  - Throughput one new operand set per cycle.
  - No handshake: every cycle is valid.
- Reset:
  - While rst is high, sum_out = 0 and carry_out = 0 immediately, independent of clk.
  - Reset asserted mid-operation discards the pending result.
  - First rising edge after rst deasserts registers the operands present at that edge.
- Inputs need not be registered. They must be stable in the setup window before the capturing edge. Changes between edges have no effect on outputs.
- Boundary cases:
  - All-ones + all-ones + 1 gives sum all-ones, carry 1.
  - All-ones + 0 + 1 wraps sum to 0 with carry 1 (full ripple path).
  - 0 + 0 + 0 gives 0, carry 0.
- No X propagation from reset: outputs are defined from time of first reset assertion.
- Timing: critical path is the WIDTH-cell carry chain. No lookahead logic is to be added.

Test Plan:
- Assert rst with nonzero operands (a_in=4'b1011, b_in=4'b0100) -> sum_out=0000, carry_out=0 immediately and throughout reset, regardless of clock edges.
- After reset: a_in=0000, b_in=0000, carry_in=0 -> one edge later sum_out=0000, carry_out=0.
- a_in=1011, b_in=0100, carry_in=0 -> next edge sum_out=1111, carry_out=0. Outputs hold the previous result until that edge.
- a_in=1111, b_in=1101, carry_in=1 -> next edge sum_out=1101, carry_out=1.
- Full ripple: a_in=1111, b_in=0000, carry_in=1 -> sum_out=0000, carry_out=1. Then assert rst asynchronously mid-cycle -> outputs drop to 0 before the next edge.
- Exhaustive check, all 512 combinations of a_in, b_in, carry_in applied back-to-back, one per cycle -> each result {carry_out,sum_out} equals a_in+b_in+carry_in, exactly one cycle later. Repeat with WIDTH=8 using random vectors.
